// File: rtl/ysyx_22051468_inst_rom.sv
// Instruction ROM with a request/response fetch port and a program-load write port.
// Optional access checking (misaligned or out-of-range fetches) is enabled by INST_ROM_ACCESS_CHECK_EN.
`timescale 1ns/1ps
module ysyx_22051468_inst_rom #(
    parameter int               WIDTH       = 64,
    parameter int               INST_WIDTH  = 32,
    parameter int               DEPTH_LOG2  = 12,
    parameter logic [WIDTH-1:0] BASE_ADDR   = 64'h8000_0000,
    parameter int               WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [WIDTH-1:0]      req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [INST_WIDTH-1:0] resp_inst,
    output logic [WIDTH-1:0]      resp_addr,
    output logic                  resp_fault,
    input  logic                  resp_ready,
    input  logic                  load_en,
    input  logic [WIDTH-1:0]      load_addr,
    input  logic [INST_WIDTH-1:0] load_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Handshake: a request transfers on an edge where req_valid && req_ready;
    // a response transfers on an edge where resp_valid && resp_ready, and the
    // response fields hold steady until then.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [WIDTH-1:0]        addr_q;
    logic                    accept;
    logic                    enter_resp;
    logic [WIDTH-1:0]        rd_addr;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [DEPTH_LOG2-1:0]   ld_idx;
    logic                    rd_fault;
    logic                    ld_ok;

    logic [INST_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_addr  = addr_q;

    // With zero wait cycles the read happens on the accepting edge, so the
    // address comes straight from the request port.
    assign rd_addr = (state == S_IDLE) ? req_addr : addr_q;
    assign rd_idx  = DEPTH_LOG2'((rd_addr - BASE_ADDR) >> 2);
    assign ld_idx  = DEPTH_LOG2'((load_addr - BASE_ADDR) >> 2);

`ifdef INST_ROM_ACCESS_CHECK_EN
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);
    // Addresses below BASE_ADDR wrap to a huge offset and fail the same test.
    assign rd_fault = (rd_addr[1:0] != 2'b00) ||
                      (((rd_addr - BASE_ADDR) >> (DEPTH_LOG2 + 2)) != '0);
    assign ld_ok    = (((load_addr - BASE_ADDR) >> (DEPTH_LOG2 + 2)) == '0);
`else
    assign rd_fault = 1'b0;
    assign ld_ok    = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            addr_q     <= '0;
            resp_inst  <= '0;
            resp_fault <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                cnt    <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt    <= cnt - 4'd1;
            end
            if (enter_resp) begin
`ifdef INST_ROM_ACCESS_CHECK_EN
                resp_inst  <= rd_fault ? NOP : mem[rd_idx];
`else
                resp_inst  <= mem[rd_idx];
`endif
                resp_fault <= rd_fault;
            end
        end
    end

    // Array is never reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (load_en && ld_ok) mem[ld_idx] <= load_data;
    end

endmodule

// File: tb/tb_ysyx_22051468_inst_rom.sv
// Directed bench for ysyx_22051468_inst_rom: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
`timescale 1ns/1ps
module tb_ysyx_22051468_inst_rom;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [63:0] load_addr;
  logic [31:0] load_data;

  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_fault, a_resp_ready;
  logic [63:0] a_req_addr, a_resp_addr;
  logic [31:0] a_resp_inst;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_fault, b_resp_ready;
  logic [63:0] b_req_addr, b_resp_addr;
  logic [31:0] b_resp_inst;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  logic [31:0] f_inst;
  logic        f_fault;
  logic [63:0] f_addr;

  ysyx_22051468_inst_rom #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_addr(a_req_addr), .req_ready(a_req_ready),
    .resp_valid(a_resp_valid), .resp_inst(a_resp_inst), .resp_addr(a_resp_addr),
    .resp_fault(a_resp_fault), .resp_ready(a_resp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  ysyx_22051468_inst_rom #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
    .resp_valid(b_resp_valid), .resp_inst(b_resp_inst), .resp_addr(b_resp_addr),
    .resp_fault(b_resp_fault), .resp_ready(b_resp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic load(input logic [63:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic fetch(input bit sel_b, input logic [63:0] a,
                       output logic [31:0] inst, output logic flt, output logic [63:0] ra);
    int n;
    if (sel_b) begin b_req_valid = 1'b1; b_req_addr = a; end
    else       begin a_req_valid = 1'b1; a_req_addr = a; end
    tick();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    n = 0;
    while (!(sel_b ? b_resp_valid : a_resp_valid) && n < 20) begin
      tick();
      n++;
    end
    check(sel_b ? "b_fetch_valid" : "a_fetch_valid", {63'd0, (sel_b ? b_resp_valid : a_resp_valid)}, 64'd1);
    inst = sel_b ? b_resp_inst  : a_resp_inst;
    flt  = sel_b ? b_resp_fault : a_resp_fault;
    ra   = sel_b ? b_resp_addr  : a_resp_addr;
    if (sel_b) b_resp_ready = 1'b1; else a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b0;
    tick(); tick();
    check("rst_resp_valid", {63'd0, a_resp_valid}, 64'd0);
    check("rst_resp_inst",  {32'd0, a_resp_inst}, 64'd0);
    check("rst_resp_addr",  a_resp_addr, 64'd0);
    check("rst_resp_fault", {63'd0, a_resp_fault}, 64'd0);
    rst = 1'b0;
    tick();
    check("rst_req_ready", {63'd0, a_req_ready}, 64'd1);

    load(64'h8000_0000, 32'h0050_0093);
    load(64'h8000_0004, 32'h0000_0073);
    load(64'h8000_0008, 32'h1111_1111);
    load(64'h8000_3FFC, 32'hCAFE_F00D);

    // WAIT_CYCLES=1: request in cycle 0, response in cycle 2
    a_req_valid = 1'b1; a_req_addr = 64'h8000_0000;
    check("w1_req_ready_idle", {63'd0, a_req_ready}, 64'd1);
    tick();
    a_req_valid = 1'b0;
    check("w1_c1_resp_valid", {63'd0, a_resp_valid}, 64'd0);
    check("w1_c1_req_ready",  {63'd0, a_req_ready}, 64'd0);
    tick();
    check("w1_c2_resp_valid", {63'd0, a_resp_valid}, 64'd1);
    check("w1_c2_resp_inst",  {32'd0, a_resp_inst}, 64'h0050_0093);
    check("w1_c2_resp_addr",  a_resp_addr, 64'h8000_0000);
    check("w1_c2_resp_fault", {63'd0, a_resp_fault}, 64'd0);
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    check("w1_back_idle_ready", {63'd0, a_req_ready}, 64'd1);
    check("w1_back_idle_valid", {63'd0, a_resp_valid}, 64'd0);

    // WAIT_CYCLES=0 with a 3-cycle stall; a request during RESP is ignored
    b_req_valid = 1'b1; b_req_addr = 64'h8000_0004;
    tick();
    b_req_addr = 64'h8000_0008;
    check("w0_resp_valid", {63'd0, b_resp_valid}, 64'd1);
    check("w0_resp_inst",  {32'd0, b_resp_inst}, 64'h0000_0073);
    check("w0_req_ready",  {63'd0, b_req_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {63'd0, b_resp_valid}, 64'd1);
      check("stall_inst",  {32'd0, b_resp_inst}, 64'h0000_0073);
      check("stall_addr",  b_resp_addr, 64'h8000_0004);
      check("stall_req_ready", {63'd0, b_req_ready}, 64'd0);
    end
    b_req_valid = 1'b0; b_resp_ready = 1'b1;
    tick();
    b_resp_ready = 1'b0;
    check("w0_release_valid", {63'd0, b_resp_valid}, 64'd0);
    check("w0_release_ready", {63'd0, b_req_ready}, 64'd1);

    // load on the edge entering RESP is not visible to that response
    a_req_valid = 1'b1; a_req_addr = 64'h8000_0008;
    tick();
    a_req_valid = 1'b0;
    load_en = 1'b1; load_addr = 64'h8000_0008; load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    check("same_edge_valid", {63'd0, a_resp_valid}, 64'd1);
    check("same_edge_old",   {32'd0, a_resp_inst}, 64'h1111_1111);
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    fetch(1'b0, 64'h8000_0008, f_inst, f_fault, f_addr);
    check("after_load_new", {32'd0, f_inst}, 64'hDEAD_BEEF);

    // reset during WAIT drops the request, keeps memory
    a_req_valid = 1'b1; a_req_addr = 64'h8000_0004;
    tick();
    a_req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait_req_ready", {63'd0, a_req_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("rst_wait_no_resp", {63'd0, a_resp_valid}, 64'd0);
      tick();
    end
    fetch(1'b0, 64'h8000_0004, f_inst, f_fault, f_addr);
    check("rst_keep_mem", {32'd0, f_inst}, 64'h0000_0073);

    // alignment / range behaviour
`ifdef INST_ROM_ACCESS_CHECK_EN
    fetch(1'b1, 64'h8000_0002, f_inst, f_fault, f_addr);
    check("mis_fault", {63'd0, f_fault}, 64'd1);
    check("mis_inst",  {32'd0, f_inst}, 64'h0000_0013);
    fetch(1'b1, 64'h7FFF_FFFC, f_inst, f_fault, f_addr);
    check("below_fault", {63'd0, f_fault}, 64'd1);
    check("below_inst",  {32'd0, f_inst}, 64'h0000_0013);
    fetch(1'b1, 64'h8000_4000, f_inst, f_fault, f_addr);
    check("above_fault", {63'd0, f_fault}, 64'd1);
    fetch(1'b1, 64'h8000_3FFC, f_inst, f_fault, f_addr);
    check("last_fault", {63'd0, f_fault}, 64'd0);
    check("last_inst",  {32'd0, f_inst}, 64'hCAFE_F00D);
`else
    fetch(1'b1, 64'h8000_0002, f_inst, f_fault, f_addr);
    check("mis_fault", {63'd0, f_fault}, 64'd0);
    check("mis_inst",  {32'd0, f_inst}, 64'h0050_0093);
    check("mis_addr",  f_addr, 64'h8000_0002);
    fetch(1'b1, 64'h7FFF_FFFC, f_inst, f_fault, f_addr);
    check("wrap_below_inst", {32'd0, f_inst}, 64'hCAFE_F00D);
    fetch(1'b1, 64'h8000_4000, f_inst, f_fault, f_addr);
    check("wrap_above_inst", {32'd0, f_inst}, 64'h0050_0093);
`endif

    // scoreboard over random words
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d;
      d = $urandom;
      load(64'h8000_0100 + 64'(4 * i), d);
      exp_q.push_back(d);
    end
    for (int i = 0; i < 5; i++) begin
      fetch(1'b1, 64'h8000_0100 + 64'(4 * i), f_inst, f_fault, f_addr);
      check("sb_inst", {32'd0, f_inst}, {32'd0, exp_q.pop_front()});
      check("sb_addr", f_addr, 64'h8000_0100 + 64'(4 * i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22051468_inst_rom.md
YSYX_22051468_INST_ROM -- requirements
Module: ysyx_22051468_inst_rom

Interface
REQ-001 SHALL have parameter WIDTH, default 64: address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32: instruction word width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 12: log2 of the word count (4096 words).
REQ-004 SHALL have parameter BASE_ADDR, default 64'h8000_0000: byte address of word 0.
REQ-005 SHALL have parameter WAIT_CYCLES, default 1, range 0..15: extra access latency.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port req_valid, input, 1: fetch request from the core.
REQ-009 SHALL have port req_addr, input, WIDTH: fetch byte address.
REQ-010 SHALL have port req_ready, output, 1: request accepted this cycle when req_valid is also 1.
REQ-011 SHALL have port resp_valid, output, 1: response available.
REQ-012 SHALL have port resp_inst, output, INST_WIDTH: fetched instruction.
REQ-013 SHALL have port resp_addr, output, WIDTH: address echoed from the accepted request.
REQ-014 SHALL have port resp_fault, output, 1: access fault flag.
REQ-015 SHALL have port resp_ready, input, 1: core consumes the response; held at 0 while the pipeline is stalled.
REQ-016 SHALL have port load_en, input, 1: program-load write strobe.
REQ-017 SHALL have port load_addr, input, WIDTH: program-load byte address.
REQ-018 SHALL have port load_data, input, INST_WIDTH: program-load word.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-020 In IDLE with req_valid=1, the block SHALL latch req_addr, load a 4-bit counter with WAIT_CYCLES, and go to WAIT (WAIT_CYCLES>0) or to RESP (WAIT_CYCLES=0).
REQ-021 In WAIT the block SHALL decrement the counter each cycle and go to RESP in the cycle the counter reaches 1.
REQ-022 Latency SHALL be fixed: a request accepted at edge N gives resp_valid=1 from edge N+1+WAIT_CYCLES.
REQ-023 Word index SHALL be ((addr - BASE_ADDR) >> 2), truncated to DEPTH_LOG2 bits; subtraction wraps modulo 2^WIDTH.
REQ-024 The memory read SHALL be registered on the edge that enters RESP, using array contents from before that edge. A load write on the same edge SHALL NOT be visible to that response.
REQ-025 In RESP, resp_valid, resp_inst, resp_addr and resp_fault SHALL stay stable until resp_ready=1. The state then returns to IDLE, so the next request is accepted one cycle later at the earliest.
REQ-026 load_en=1 SHALL write load_data to the word at the load_addr index in any FSM state; it SHALL NOT affect the FSM.
REQ-027 resp_valid SHALL be 0 in IDLE and WAIT; req_valid in WAIT or RESP SHALL be ignored and not queued.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, counter 0, resp_valid 0, resp_inst 0, resp_addr 0, resp_fault 0. req_ready SHALL be 1 after the edge at which rst falls.
REQ-029 Reset in WAIT or RESP SHALL discard the in-flight request without producing a response; the memory array SHALL NOT be cleared.

Configuration
REQ-030 Macro INST_ROM_ACCESS_CHECK_EN defined: a request with addr[1:0]!=0, addr<BASE_ADDR, or addr>=BASE_ADDR+4*2^DEPTH_LOG2 SHALL give resp_fault=1 and resp_inst=32'h0000_0013 (NOP), with unchanged latency. Out-of-range load writes SHALL be dropped.
REQ-031 Macro INST_ROM_ACCESS_CHECK_EN undefined: addr[1:0] SHALL be ignored, the index SHALL wrap per REQ-023, and resp_fault SHALL be tied to 0.

Verification
REQ-032 Load 0x00500093 at 0x80000000, WAIT_CYCLES=1, request 0x80000000 at cycle 0 -> resp_valid at cycle 2, resp_inst=0x00500093, resp_addr=0x80000000, resp_fault=0.
REQ-033 WAIT_CYCLES=0, request 0x80000004 holding 0x00000073 -> resp_valid the next cycle; with resp_ready=0 for 3 cycles, the outputs stay unchanged; req_ready=0 throughout; IDLE only after resp_ready=1.
REQ-034 A load of 0xDEADBEEF to the requested address on the edge entering RESP -> the response carries the old word; the next request to the same address returns 0xDEADBEEF.
REQ-035 Assert rst while in WAIT -> resp_valid never rises for that request; req_ready=1 after the reset edge; previously loaded words still read back.
REQ-036 With INST_ROM_ACCESS_CHECK_EN, requests 0x80000002 and 0x7FFFFFFC -> resp_fault=1, resp_inst=0x00000013. Without the macro, 0x80000002 returns the word at 0x80000000 with resp_fault=0.
